// File: rtl/hilo_muldiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: operation codes,
// controller states and divider iteration count.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    DIV_RUN = 2'b01,
    DIV_FIX = 2'b10
  } state_e;

  localparam int DIV_ITERS = 32;
  localparam int CNT_W     = $clog2(DIV_ITERS + 1);

  function automatic logic is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// Operand, MTHI/MTLO and result bundle between the controller/register file
// and the multiply/divide unit.
interface hilo_muldiv_if #(parameter int WIDTH = 32);
  logic             clk_enable;
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output clk_enable, start, op, a, b, mthi, mtlo, wdata,
    input  busy, hi, lo
  );

  modport slave (
    input  clk_enable, start, op, a, b, mthi, mtlo, wdata,
    output busy, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_div_iter.sv
// Unsigned restoring divider core: one shift-subtract step per enabled cycle,
// DIV_ITERS steps per divide. o_done marks the cycle of the final step.
module div_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder
);

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [CNT_W-1:0] r_cnt;
  logic             r_run;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fit;

  // Partial remainder never exceeds the divisor, so WIDTH+1 bits of trial
  // difference are enough to tell whether the subtraction fits.
  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_div};
  assign w_fit   = ~w_diff[WIDTH];
  assign o_done  = r_run && (r_cnt == CNT_W'(DIV_ITERS - 1));

  assign o_quotient  = r_quo;
  assign o_remainder = r_rem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rem <= '0;
      r_quo <= '0;
      r_div <= '0;
      r_cnt <= '0;
      r_run <= 1'b0;
    end else if (i_en) begin
      if (i_start) begin
        r_rem <= '0;
        r_quo <= i_dividend;
        r_div <= i_divisor;
        r_cnt <= '0;
        r_run <= 1'b1;
      end else if (r_run) begin
        r_rem <= w_fit ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_quo <= {r_quo[WIDTH-2:0], w_fit};
        r_cnt <= r_cnt + 1'b1;
        if (o_done) r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// MIPS HI/LO multiply/divide unit: single-cycle multiply, 33-cycle iterative
// divide with sign fix-up, MTHI/MTLO writes and a busy stall indication.
module hilo_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset,
  hilo_muldiv_if.slave bus
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dz;
  logic [WIDTH-1:0] r_a_orig;

  logic             w_en;
  logic             w_idle;
  logic             w_div_start;
  logic             w_signed;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic [2*WIDTH-1:0] w_prod;
  logic             w_div_done;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] w_rem;
  logic             w_hi_we;
  logic             w_lo_we;
  logic [WIDTH-1:0] w_hi_d;
  logic [WIDTH-1:0] w_lo_d;

  assign w_en        = bus.clk_enable;
  assign w_idle      = (r_state == IDLE);
  assign w_div_start = w_idle && bus.start && is_div(bus.op);
  assign w_signed    = (bus.op == OP_DIV);
  assign w_a_mag     = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign w_b_mag     = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;

  // The low 2*WIDTH bits of the product of sign-extended operands equal the
  // signed product, so both flavours share one plain multiplier form.
  assign w_prod_s = {{WIDTH{bus.a[WIDTH-1]}}, bus.a} * {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
  assign w_prod_u = {{WIDTH{1'b0}}, bus.a} * {{WIDTH{1'b0}}, bus.b};
  assign w_prod   = (bus.op == OP_MULT) ? w_prod_s : w_prod_u;

  div_iter #(.WIDTH(WIDTH)) u_div_iter (
    .clk         (clk),
    .reset       (reset),
    .i_en        (w_en),
    .i_start     (w_div_start),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_done      (w_div_done),
    .o_quotient  (w_quo),
    .o_remainder (w_rem)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_neg  <= 1'b0;
      r_r_neg  <= 1'b0;
      r_dz     <= 1'b0;
      r_a_orig <= '0;
    end else if (w_en && w_div_start) begin
      r_q_neg  <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      r_r_neg  <= w_signed && bus.a[WIDTH-1];
      r_dz     <= (bus.b == '0);
      r_a_orig <= bus.a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)     r_state <= IDLE;
    else if (w_en) r_state <= w_state_nxt;
  end

  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned and infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_div_start) w_state_nxt = DIV_RUN;
      DIV_RUN: if (w_div_done)  w_state_nxt = DIV_FIX;
      DIV_FIX: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_hi_we = 1'b0;
    w_lo_we = 1'b0;
    w_hi_d  = bus.wdata;
    w_lo_d  = bus.wdata;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (!is_div(bus.op)) begin
            w_hi_we = 1'b1;
            w_lo_we = 1'b1;
            w_hi_d  = w_prod[2*WIDTH-1:WIDTH];
            w_lo_d  = w_prod[WIDTH-1:0];
          end
        end else begin
          w_hi_we = bus.mthi;
          w_lo_we = bus.mtlo;
        end
      end
      DIV_FIX: begin
        w_hi_we = 1'b1;
        w_lo_we = 1'b1;
        if (r_dz) begin
          w_hi_d = r_a_orig;
          w_lo_d = '1;
        end else begin
          w_hi_d = r_r_neg ? -w_rem : w_rem;
          w_lo_d = r_q_neg ? -w_quo : w_quo;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_en) begin
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
    end
  end

  assign bus.busy = !w_idle;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
